// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external memory bus between Icache line refills
// and Dcache refills/stores. One owner at a time, multi-beat line bursts, and a
// per-beat ack timeout that aborts a transaction on a dead bus.
// Optional build macro ARB_RR_EN: round-robin on contention instead of fixed
// Dcache priority.
module mem_bus_arbiter #(
  parameter int LINE_WORDS  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  output logic        ic_gnt_o,
  output logic        ic_rvalid_o,
  output logic [31:0] ic_rdata_o,
  output logic        ic_done_o,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [31:0] dc_addr_i,
  input  logic [31:0] dc_wdata_i,
  input  logic [1:0]  dc_width_i,
  output logic        dc_gnt_o,
  output logic        dc_rvalid_o,
  output logic [31:0] dc_rdata_o,
  output logic        dc_done_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  mem_width_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        arb_busy_o,
  output logic        arb_err_o
);

  localparam int          BW        = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IC_RD = 2'd1;
  localparam logic [1:0] S_DC_RD = 2'd2;
  localparam logic [1:0] S_DC_WR = 2'd3;

  logic [1:0]    r_state;
  logic [BW-1:0] r_beat;
  logic [9:0]    r_tmo;
  logic          r_first;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_width;
  logic          r_rst_q;

  logic        w_oe;
  logic        w_active;
  logic        w_any_req;
  logic        w_pick_dc;
  logic        w_is_wr;
  logic [31:0] w_sel_addr;
  logic        w_tmo_hit;
  logic        w_last_beat;
  logic        w_done;
  logic [31:0] w_beat_off;
  logic        w_ic_rd;
  logic        w_dc_rd;
  logic        w_dc_wr;

  // Outputs are held quiet during reset and the cycle right after it.
  assign w_oe      = ~rst & ~r_rst_q;
  assign w_active  = (r_state != S_IDLE);
  assign w_any_req = ic_req_i | dc_req_i;
  assign w_ic_rd   = (r_state == S_IC_RD);
  assign w_dc_rd   = (r_state == S_DC_RD);
  assign w_dc_wr   = (r_state == S_DC_WR);

`ifdef ARB_RR_EN
  logic r_last_dc;   // last granted requester: 0 = Icache, 1 = Dcache
  // On contention the requester that did not win last time gets the bus.
  assign w_pick_dc = dc_req_i & (~ic_req_i | ~r_last_dc);

  // Remember who was granted most recently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_dc <= 1'b0;
    end else if (!w_active && w_any_req) begin
      r_last_dc <= w_pick_dc;
    end
  end
`else
  // Dcache wins any tie: its miss belongs to the older instruction.
  assign w_pick_dc = dc_req_i;
`endif

  assign w_is_wr    = w_pick_dc & dc_we_i;
  assign w_sel_addr = w_pick_dc ? dc_addr_i : ic_addr_i;

  // The N-th consecutive cycle without an ack (N = TIMEOUT_CYC) aborts.
  assign w_tmo_hit   = w_active & ~mem_ack_i & (r_tmo == 10'(TIMEOUT_CYC - 1));
  assign w_last_beat = (w_ic_rd | w_dc_rd) & mem_ack_i & (r_beat == BW'(LINE_WORDS - 1));
  assign w_done      = w_last_beat | (w_dc_wr & mem_ack_i) | w_tmo_hit;
  assign w_beat_off  = {{(30 - BW){1'b0}}, r_beat, 2'b00};

  // Reset-release tracker used to gate outputs for one extra cycle.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  // Arbitration, capture, beat sequencing and timeout counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_tmo   <= '0;
      r_first <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_width <= '0;
    end else if (!w_active) begin
      r_first <= 1'b0;
      r_beat  <= '0;
      r_tmo   <= '0;
      if (w_any_req) begin
        r_state <= w_pick_dc ? (dc_we_i ? S_DC_WR : S_DC_RD) : S_IC_RD;
        r_first <= 1'b1;
        r_addr  <= w_is_wr ? dc_addr_i : (w_sel_addr & ~LINE_MASK);
        r_wdata <= w_is_wr ? dc_wdata_i : 32'd0;
        r_width <= w_is_wr ? dc_width_i : 2'b10;
      end
    end else begin
      r_first <= 1'b0;
      if (w_done) begin
        r_state <= S_IDLE;
        r_beat  <= '0;
        r_tmo   <= '0;
      end else if (mem_ack_i) begin
        r_tmo  <= '0;
        r_beat <= r_beat + 1'b1;
      end else begin
        r_tmo <= r_tmo + 10'd1;
      end
    end
  end

  assign mem_req_o   = w_oe & w_active;
  assign mem_we_o    = w_oe & w_dc_wr;
  assign mem_addr_o  = (w_oe & w_active) ? (r_addr + w_beat_off) : 32'd0;
  assign mem_wdata_o = (w_oe & w_active) ? r_wdata : 32'd0;
  assign mem_width_o = (w_oe & w_active) ? r_width : 2'b00;

  assign ic_gnt_o    = w_oe & w_ic_rd & r_first;
  assign ic_rvalid_o = w_oe & w_ic_rd & mem_ack_i;
  assign ic_rdata_o  = ic_rvalid_o ? mem_rdata_i : 32'd0;
  assign ic_done_o   = w_oe & w_ic_rd & w_done;

  assign dc_gnt_o    = w_oe & (w_dc_rd | w_dc_wr) & r_first;
  assign dc_rvalid_o = w_oe & w_dc_rd & mem_ack_i;
  assign dc_rdata_o  = dc_rvalid_o ? mem_rdata_i : 32'd0;
  assign dc_done_o   = w_oe & (w_dc_rd | w_dc_wr) & w_done;

  assign arb_busy_o  = w_oe & (w_active | w_any_req);
  assign arb_err_o   = w_oe & w_tmo_hit;

endmodule
